// File: rtl/hazard_unit_mc.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_unit_mc
//  Purpose  : Hazard unit for a 5-stage MIPS pipeline.
//             - E-stage forwarding for both ALU operands.
//             - Decode-stage forwarding of ALUOutM into the branch comparator.
//             - Stalls for load-use hazards and for branch operands that are
//               not ready yet.
//             - Scoreboard for a multi-cycle MUL/DIV unit.
//             - Decode flush on a taken branch or a jump.
//             - Saturating counter of stalled cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_unit_mc #(
    parameter int REG_AW  = 5,
    parameter int MD_LAT  = 4,
    parameter int FWD_DEC = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              BranchD,
    input  logic              JumpD,
    input  logic              BranchTakenD,
    input  logic              MulDivD,
    input  logic              MfHiLoD,
    input  logic [REG_AW-1:0] RsD,
    input  logic [REG_AW-1:0] RtD,
    input  logic [REG_AW-1:0] RsE,
    input  logic [REG_AW-1:0] RtE,
    input  logic [REG_AW-1:0] WriteRegE,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic [REG_AW-1:0] WriteRegW,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              MemtoRegE,
    input  logic              MemtoRegM,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic              ForwardAD,
    output logic              ForwardBD,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              MdStart,
    output logic              MdBusy,
    output logic [CNT_W-1:0]  StallCnt
);

    // Value loaded into the MUL/DIV countdown on accept (legal range 1..255)
    localparam logic [7:0]       MD_LOAD = 8'(MD_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [7:0] md_cnt;

    // Per-stage register hits; register 0 never counts as a writer
    logic m_wr_valid;
    logic w_wr_valid;
    logic e_wr_valid;
    logic m_hit_rs_e;
    logic m_hit_rt_e;
    logic w_hit_rs_e;
    logic w_hit_rt_e;
    logic m_hit_rs_d;
    logic m_hit_rt_d;
    logic e_hit_d;
    logic mload_hit_d;
    logic late_hit_d;

    logic lwstall;
    logic brstall;
    logic mdstall;
    logic stall;

    assign m_wr_valid  = RegWriteM && (WriteRegM != '0);
    assign w_wr_valid  = RegWriteW && (WriteRegW != '0);
    assign e_wr_valid  = RegWriteE && (WriteRegE != '0);

    assign m_hit_rs_e  = m_wr_valid && (WriteRegM == RsE);
    assign m_hit_rt_e  = m_wr_valid && (WriteRegM == RtE);
    assign w_hit_rs_e  = w_wr_valid && (WriteRegW == RsE);
    assign w_hit_rt_e  = w_wr_valid && (WriteRegW == RtE);

    assign m_hit_rs_d  = m_wr_valid && (WriteRegM == RsD);
    assign m_hit_rt_d  = m_wr_valid && (WriteRegM == RtD);

    assign e_hit_d     = e_wr_valid && ((WriteRegE == RsD) || (WriteRegE == RtD));
    // A load in M cannot be forwarded to decode: its data only exists in W
    assign mload_hit_d = MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD));

    // Decode forwarding is either present, or replaced by stalling on M/W writers
    generate
        if (FWD_DEC != 0) begin : g_fwd_dec_on
            assign ForwardAD  = m_hit_rs_d;
            assign ForwardBD  = m_hit_rt_d;
            assign late_hit_d = 1'b0;
        end else begin : g_fwd_dec_off
            assign ForwardAD  = 1'b0;
            assign ForwardBD  = 1'b0;
            assign late_hit_d = m_hit_rs_d || m_hit_rt_d ||
                                (w_wr_valid && ((WriteRegW == RsD) || (WriteRegW == RtD)));
        end
    endgenerate

    // E-stage operand select: the younger M-stage result wins over W
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (m_hit_rs_e)      ForwardAE = 2'b10;
        else if (w_hit_rs_e) ForwardAE = 2'b01;
        if (m_hit_rt_e)      ForwardBE = 2'b10;
        else if (w_hit_rt_e) ForwardBE = 2'b01;
    end

    assign MdBusy  = (md_cnt != 8'd0);

    // Stall sources and resulting pipeline control
    always_comb begin
        lwstall = MemtoRegE && (RtE != '0) && ((RtE == RsD) || (RtE == RtD));
        brstall = BranchD && (e_hit_d || mload_hit_d || late_hit_d);
        mdstall = MdBusy && (MulDivD || MfHiLoD);
        stall   = lwstall || brstall || mdstall;
    end

    assign StallF  = stall;
    assign StallD  = stall;
    assign FlushE  = stall;
    // A stalled branch is re-evaluated next cycle, so no flush while stalled
    assign FlushD  = !stall && (JumpD || (BranchD && BranchTakenD));
    assign MdStart = MulDivD && !stall;

    // MUL/DIV countdown: reload on accept, otherwise drain while busy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            md_cnt <= 8'd0;
        end else if (MdStart) begin
            md_cnt <= MD_LOAD;
        end else if (MdBusy) begin
            md_cnt <= md_cnt - 8'd1;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            StallCnt <= '0;
        end else if (stall && (StallCnt != CNT_MAX)) begin
            StallCnt <= StallCnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_unit_mc
//  Purpose  : Directed self-checking bench for hazard_unit_mc; a second
//             instance with a 2-bit stall counter covers saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_unit_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic       BranchD, JumpD, BranchTakenD, MulDivD, MfHiLoD;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;

    logic        StallF, StallD, FlushD, FlushE, ForwardAD, ForwardBD;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        MdStart, MdBusy;
    logic [15:0] StallCnt;

    logic        s_StallF, s_StallD, s_FlushD, s_FlushE, s_ForwardAD, s_ForwardBD;
    logic [1:0]  s_ForwardAE, s_ForwardBE;
    logic        s_MdStart, s_MdBusy;
    logic [1:0]  s_StallCnt;

    typedef struct {
        string       tag;
        logic [27:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 clk = ~clk;

    hazard_unit_mc #(.REG_AW(5), .MD_LAT(4), .FWD_DEC(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .BranchD(BranchD), .JumpD(JumpD), .BranchTakenD(BranchTakenD),
        .MulDivD(MulDivD), .MfHiLoD(MfHiLoD),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .MdStart(MdStart), .MdBusy(MdBusy), .StallCnt(StallCnt)
    );

    hazard_unit_mc #(.REG_AW(5), .MD_LAT(4), .FWD_DEC(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .BranchD(BranchD), .JumpD(JumpD), .BranchTakenD(BranchTakenD),
        .MulDivD(MulDivD), .MfHiLoD(MfHiLoD),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
        .StallF(s_StallF), .StallD(s_StallD), .FlushD(s_FlushD), .FlushE(s_FlushE),
        .ForwardAD(s_ForwardAD), .ForwardBD(s_ForwardBD),
        .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE),
        .MdStart(s_MdStart), .MdBusy(s_MdBusy), .StallCnt(s_StallCnt)
    );

    // All DUT inputs back to an idle pipeline
    task automatic clr();
        BranchD = 0; JumpD = 0; BranchTakenD = 0; MulDivD = 0; MfHiLoD = 0;
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; MemtoRegM = 0;
    endtask

    // Push the expected output vector, let logic settle, then pop and compare
    task automatic chk(input string tag, input logic st, input logic fd,
                       input logic ad, input logic bd,
                       input logic [1:0] ae, input logic [1:0] be,
                       input logic ms, input logic mb, input logic [15:0] cnt);
        exp_t        e;
        logic [27:0] obs;
        e.tag = tag;
        e.v   = {st, st, st, fd, ad, bd, ae, be, ms, mb, cnt};
        sb.push_back(e);
        #2;
        e   = sb.pop_front();
        obs = {StallF, StallD, FlushE, FlushD, ForwardAD, ForwardBD,
               ForwardAE, ForwardBE, MdStart, MdBusy, StallCnt};
        n_checks++;
        assert (obs === e.v) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
        end
    endtask

    // Stall counter of the narrow instance
    task automatic chk_sat(input string tag, input logic [1:0] cnt);
        n_checks++;
        assert (s_StallCnt === cnt) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, s_StallCnt, cnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        clr();
        chk("reset", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 16'd0);
        chk_sat("reset_sat", 2'd0);
        @(negedge clk); rst = 1'b1;

        // E-stage forwarding
        @(negedge clk); clr();
        RegWriteM = 1; WriteRegM = 5; RegWriteW = 1; WriteRegW = 5; RsE = 5;
        chk("fwd_ae_m_over_w", 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 16'd0);
        @(negedge clk); clr();
        RegWriteM = 1; WriteRegM = 0; RegWriteW = 1; WriteRegW = 5; RsE = 0;
        chk("fwd_ae_reg0", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 16'd0);
        @(negedge clk); clr();
        RegWriteM = 1; WriteRegM = 7; RegWriteW = 1; WriteRegW = 9; RsE = 7; RtE = 9;
        chk("fwd_ae_m_be_w", 0, 0, 0, 0, 2'b10, 2'b01, 0, 0, 16'd0);

        // Load-use stall
        @(negedge clk); clr();
        MemtoRegE = 1; RegWriteE = 1; WriteRegE = 2; RtE = 2; RsD = 2;
        chk("lwstall", 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 16'd0);
        @(negedge clk); clr();
        MemtoRegM = 1; RegWriteM = 1; WriteRegM = 2; RsD = 2;
        chk("lw_released", 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 16'd1);

        // Branch operand hazards and decode flush
        @(negedge clk); clr();
        BranchD = 1; BranchTakenD = 1; RsD = 6; RegWriteE = 1; WriteRegE = 6;
        chk("brstall_e_noflush", 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 16'd1);
        @(negedge clk); clr();
        BranchD = 1; RsD = 6; RegWriteM = 1; WriteRegM = 6;
        chk("br_fwd_ad", 0, 0, 1, 0, 2'b00, 2'b00, 0, 0, 16'd2);
        @(negedge clk); clr();
        BranchD = 1; BranchTakenD = 1; RsD = 6; RegWriteM = 1; WriteRegM = 6;
        chk("br_taken_flush", 0, 1, 1, 0, 2'b00, 2'b00, 0, 0, 16'd2);
        @(negedge clk); clr();
        JumpD = 1;
        chk("jump_flush", 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 16'd2);
        @(negedge clk); clr();
        BranchD = 1; RtD = 8; MemtoRegM = 1; RegWriteM = 1; WriteRegM = 8;
        chk("brstall_load_m", 1, 0, 0, 1, 2'b00, 2'b00, 0, 0, 16'd2);
        @(negedge clk); clr();
        MemtoRegE = 1; RtE = 0; RsD = 0;
        chk("lw_reg0_nostall", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 16'd3);

        // MUL/DIV accept followed by MFLO
        @(negedge clk); clr();
        MulDivD = 1;
        chk("md_start", 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 16'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); clr();
            MfHiLoD = 1;
            chk("mflo_wait", 1, 0, 0, 0, 2'b00, 2'b00, 0, 1, 16'(3 + i));
        end
        @(negedge clk); clr();
        MfHiLoD = 1;
        chk("mflo_go", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 16'd7);

        // Back-to-back MUL/DIV
        @(negedge clk); clr();
        MulDivD = 1;
        chk("mult1_start", 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 16'd7);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); clr();
            MulDivD = 1;
            chk("mult2_wait", 1, 0, 0, 0, 2'b00, 2'b00, 0, 1, 16'(7 + i));
        end
        @(negedge clk); clr();
        MulDivD = 1;
        chk("mult2_accept", 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 16'd11);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); clr();
            chk("mult2_busy", 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 16'd11);
        end
        @(negedge clk); clr();
        chk("mult2_done", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 16'd11);

        // MUL/DIV held by a load-use stall must not start
        @(negedge clk); clr();
        MulDivD = 1; MemtoRegE = 1; RtE = 3; RsD = 3;
        chk("md_held_lw", 1, 0, 0, 0, 2'b00, 2'b00, 0, 0, 16'd11);
        @(negedge clk); clr();
        chk("md_held_idle", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 16'd12);
        chk_sat("sat_cnt", 2'd3);

        // Asynchronous reset in the middle of a MUL/DIV
        @(negedge clk); clr();
        MulDivD = 1;
        chk("md_start2", 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 16'd12);
        @(negedge clk); clr();
        chk("md_busy2", 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 16'd12);
        @(negedge clk); clr();
        rst = 1'b0;
        chk("async_reset", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 16'd0);
        chk_sat("async_reset_sat", 2'd0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); clr();
        chk("post_reset_idle", 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised next-generation hazard unit for the 5-stage MIPS pipeline.
- Provides E-stage forwarding, decode-stage branch forwarding, load-use stalls and branch-operand stalls.
- Adds a scoreboard for a multi-cycle MUL/DIV unit, a decode flush for taken control transfers, and a saturating stall-cycle counter.
- Sits beside the control unit and is driven by the datapath pipeline-register fields.

Parameters:
- REG_AW, 5: register address width; address 0 is hard-wired zero and is never forwarded.
- MD_LAT, 4: MUL/DIV latency in cycles; legal range 1..255.
- FWD_DEC, 1: 1 enables ForwardAD/BD; 0 ties both to 0 and the branch stall then also covers a W-stage writer.
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- BranchD, JumpD  in  1  control-transfer instruction in decode
- BranchTakenD  in  1  branch compare resolved as taken in decode
- MulDivD  in  1  MUL/DIV instruction in decode
- MfHiLoD  in  1  MFHI/MFLO instruction in decode
- RsD, RtD, RsE, RtE  in  REG_AW  source register fields
- WriteRegE, WriteRegM, WriteRegW  in  REG_AW  destination register fields
- RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM  in  1  stage control bits
- StallF, StallD  out  1  hold PC / hold IF-ID register
- FlushD, FlushE  out  1  clear IF-ID / clear ID-EX register
- ForwardAD, ForwardBD  out  1  forward ALUOutM to the branch comparator
- ForwardAE, ForwardBE  out  2  00 = regfile, 10 = ALUOutM, 01 = ResultW
- MdStart  out  1  MUL/DIV accepted this cycle
- MdBusy  out  1  MUL/DIV in flight
- StallCnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (rst=0, asynchronous):
  - md_cnt and StallCnt clear to 0 immediately, including mid-operation; MdBusy=0.
  - All other outputs are combinational and follow their inputs.
- ForwardAE priority:
  - 10 if RegWriteM && WriteRegM!=0 && WriteRegM==RsE.
  - Else 01 if RegWriteW && WriteRegW!=0 && WriteRegW==RsE.
  - Else 00. The M stage wins over the W stage.
- ForwardBE: same rules applied to RtE.
- ForwardAD = FWD_DEC && RegWriteM && WriteRegM!=0 && WriteRegM==RsD; ForwardBD is the same with RtD.
- lwstall = MemtoRegE && RtE!=0 && (RtE==RsD || RtE==RtD).
- brstall = BranchD && any of:
  - RegWriteE && WriteRegE!=0 && WriteRegE matches RsD or RtD;
  - MemtoRegM && WriteRegM matches RsD or RtD;
  - if FWD_DEC=0: RegWriteM or RegWriteW with a matching nonzero destination.
- mdstall = MdBusy && (MulDivD || MfHiLoD).
- Stall and flush outputs:
  - stall = lwstall | brstall | mdstall.
  - StallF = StallD = FlushE = stall.
  - FlushD = !StallD && (JumpD || (BranchD && BranchTakenD)). FlushD is suppressed while stalled so a stalled branch resolves on retry.
- MUL/DIV scoreboard:
  - md_cnt width is 8 bits. MdBusy = (md_cnt != 0). MdStart = MulDivD && !stall.
  - Each clock: if MdStart, md_cnt <= MD_LAT; else if MdBusy, md_cnt <= md_cnt-1.
  - Result: exactly MD_LAT busy cycles follow the accept cycle.
  - Back-to-back MUL/DIV: the second one stalls until md_cnt reaches 0, then is accepted that cycle and reloads.
  - MUL/DIV held by lwstall/brstall does not load the counter.
  - MFHI/MFLO issued on the cycle md_cnt==0 proceeds with no stall.
- StallCnt:
  - Increments by 1 on every clock with stall=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by reset.

Test Plan:
- lw $2 in E, add $4,$2,$3 in D (MemtoRegE=1, RtE=2, RsD=2) -> StallF=StallD=FlushE=1 for 1 cycle; StallCnt 0->1.
- RegWriteM=1, WriteRegM=5 and RegWriteW=1, WriteRegW=5, RsE=5 -> ForwardAE=10. Repeat with WriteRegM=0, RsE=0 -> ForwardAE=00.
- beq $6 in D with RegWriteE=1, WriteRegE=6 -> 1-cycle stall. Next cycle (writer now in M) ForwardAD=1 with no stall. Set BranchTakenD=1 -> FlushD=1.
- MD_LAT=4: mult accepted (MdStart=1), then mflo in D -> MdBusy high 4 cycles; stall for 4 cycles; mflo proceeds on cycle 5; StallCnt=4.
- Back-to-back mult, mult -> second is accepted exactly when md_cnt==0; md_cnt reloads to 4, never going through an idle cycle.
- Assert rst=0 with md_cnt=3 -> MdBusy=0 and StallCnt=0 asynchronously. CNT_W=2 with 5 stall cycles -> StallCnt=3 (saturated).
